// File: rtl/x_oddr_pkg.sv
// Shared types and helpers for the DDR output-pair serializer and its lanes.
package x_oddr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam string ORDER_LSB_FIRST = "LSB_FIRST";
   localparam string ORDER_MSB_FIRST = "MSB_FIRST";

   localparam int MAX_WIDTH = 16;

   // Returns {D2, D1} for pair k of a lane word that is 'width' bits wide.
   function automatic logic [1:0] pair_sel(
      input logic [MAX_WIDTH-1:0] word,
      input logic [3:0]           k,
      input logic [4:0]           width,
      input logic                 msb_first
   );
      logic [3:0] lo;
      lo = msb_first ? 4'(width - 5'd2 - {k, 1'b0}) : {k[2:0], 1'b0};
      return msb_first ? {word[lo], word[lo + 4'd1]} : {word[lo + 4'd1], word[lo]};
   endfunction

endpackage

// File: rtl/x_oddr_ser_lane.sv
// One lane of the serializer: shift-register slice plus registered D1/D2 pair.
module x_oddr_ser_lane
   import x_oddr_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter int   KW        = 2,
   parameter logic INIT      = 1'b0,
   parameter bit   MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             advance,
   input  logic             go_idle,
   input  logic [WIDTH-1:0] load_word,
   input  logic [KW-1:0]    next_k,
   output logic             d1,
   output logic             d2
);

   logic [WIDTH-1:0]     sr;
   logic [MAX_WIDTH-1:0] load_ext;
   logic [MAX_WIDTH-1:0] sr_ext;
   logic [1:0]           load_pair;
   logic [1:0]           shift_pair;

   always_comb begin
      load_ext             = '0;
      load_ext[WIDTH-1:0]  = load_word;
      sr_ext               = '0;
      sr_ext[WIDTH-1:0]    = sr;
      load_pair            = pair_sel(load_ext, 4'd0, 5'(WIDTH), MSB_FIRST);
      shift_pair           = pair_sel(sr_ext, 4'(next_k), 5'(WIDTH), MSB_FIRST);
   end

   // A fresh word drives its pair 0 on the same edge it lands in the slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
         d1 <= INIT;
         d2 <= INIT;
      end else if (load) begin
         sr       <= load_word;
         {d2, d1} <= load_pair;
      end else if (advance) begin
         {d2, d1} <= shift_pair;
      end else if (go_idle) begin
         d1 <= INIT;
         d2 <= INIT;
      end
   end

endmodule

// File: rtl/x_oddr_serializer.sv
// Parallel-word to per-lane DDR pair serializer with a two-deep word buffer,
// valid/ready input, underrun flag and bitslip.
module x_oddr_serializer
   import x_oddr_pkg::*;
#(
   parameter int    WIDTH     = 8,
   parameter int    LANES     = 1,
   parameter logic  INIT      = 1'b0,
   parameter string BIT_ORDER = ORDER_LSB_FIRST
) (
   input  logic                   C,
   input  logic                   RN,
   input  logic                   CE,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [LANES*WIDTH-1:0] IN_DATA,
   input  logic                   BITSLIP,
   output logic [LANES-1:0]       D1,
   output logic [LANES-1:0]       D2,
   output logic                   BUSY,
   output logic                   UNDERRUN
);

   localparam int            KW        = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   localparam bit            MSB_ORDER = (BIT_ORDER == ORDER_MSB_FIRST);
   localparam logic [KW-1:0] K_LAST    = KW'(WIDTH / 2 - 1);

   state_t                   state, state_next;
   logic [KW-1:0]            k, k_next;
   logic [LANES*WIDTH-1:0]   pend;
   logic                     pend_v;
   logic                     underrun_q, underrun_next;
   logic                     xfer, src_avail, last;
   logic                     do_load, do_adv, do_idle;
   logic [LANES*WIDTH-1:0]   src_word;

   assign xfer      = IN_VALID && !pend_v;
   assign src_avail = pend_v || xfer;
   assign src_word  = pend_v ? pend : IN_DATA;
   assign last      = (k == K_LAST);

   assign IN_READY  = !pend_v;
   assign BUSY      = (state == SHIFT);
   assign UNDERRUN  = underrun_q;

   // Everything in the shift path waits on CE; BITSLIP outranks a word end.
   always_comb begin
      state_next    = state;
      k_next        = k;
      underrun_next = 1'b0;
      do_load       = 1'b0;
      do_adv        = 1'b0;
      do_idle       = 1'b0;
      if (CE) begin
         case (state)
            IDLE: begin
               if (src_avail) begin
                  do_load    = 1'b1;
                  state_next = SHIFT;
                  k_next     = '0;
               end else begin
                  do_idle = 1'b1;
               end
            end
            SHIFT: begin
               if (BITSLIP) begin
                  k_next = k;
               end else if (!last) begin
                  do_adv = 1'b1;
                  k_next = k + KW'(1);
               end else if (src_avail) begin
                  do_load = 1'b1;
                  k_next  = '0;
               end else begin
                  do_idle       = 1'b1;
                  state_next    = IDLE;
                  k_next        = '0;
                  underrun_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state      <= IDLE;
         k          <= '0;
         underrun_q <= 1'b0;
      end else begin
         state      <= state_next;
         k          <= k_next;
         underrun_q <= underrun_next;
      end
   end

   // A transfer not consumed by a bypass load parks in PEND, even with CE low.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         pend   <= '0;
         pend_v <= 1'b0;
      end else if (do_load && pend_v) begin
         pend_v <= 1'b0;
      end else if (xfer && !do_load) begin
         pend   <= IN_DATA;
         pend_v <= 1'b1;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      x_oddr_ser_lane #(
         .WIDTH     (WIDTH),
         .KW        (KW),
         .INIT      (INIT),
         .MSB_FIRST (MSB_ORDER)
      ) u_lane (
         .clk       (C),
         .rst_n     (RN),
         .load      (do_load),
         .advance   (do_adv),
         .go_idle   (do_idle),
         .load_word (src_word[l*WIDTH +: WIDTH]),
         .next_k    (k_next),
         .d1        (D1[l]),
         .d2        (D2[l])
      );
   end

endmodule

// File: tb/tb_x_oddr_serializer.sv
// Bench for x_oddr_serializer: directed scenarios plus a randomized run against
// a queue-based reference model; two instances share the control inputs.
module tb_x_oddr_serializer;

   logic        C;
   logic        RN;
   logic        CE;
   logic        IN_VALID;
   logic        BITSLIP;
   logic [7:0]  data_a;
   logic [31:0] data_b;
   logic        ready_a, busy_a, und_a, d1_a, d2_a;
   logic        ready_b, busy_b, und_b;
   logic [3:0]  d1_b, d2_b;

   int errors = 0;
   int checks = 0;

   x_oddr_serializer #(
      .WIDTH(8), .LANES(1), .INIT(1'b1), .BIT_ORDER("LSB_FIRST")
   ) dut_a (
      .C(C), .RN(RN), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(ready_a),
      .IN_DATA(data_a), .BITSLIP(BITSLIP), .D1(d1_a), .D2(d2_a),
      .BUSY(busy_a), .UNDERRUN(und_a)
   );

   x_oddr_serializer #(
      .WIDTH(8), .LANES(4), .INIT(1'b0), .BIT_ORDER("MSB_FIRST")
   ) dut_b (
      .C(C), .RN(RN), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(ready_b),
      .IN_DATA(data_b), .BITSLIP(BITSLIP), .D1(d1_b), .D2(d2_b),
      .BUSY(busy_b), .UNDERRUN(und_b)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   // {D2, D1} for pair p of an LSB-first byte
   function automatic logic [1:0] ref_lsb(input logic [7:0] w, input int p);
      return {w[2*p+1], w[2*p]};
   endfunction

   // {D2[3:0], D1[3:0]} for pair p of four MSB-first byte lanes
   function automatic logic [7:0] ref_msb4(input logic [31:0] w, input int p);
      logic [7:0] r;
      logic [7:0] b;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         b        = w[l*8 +: 8];
         r[l]     = b[7-2*p];
         r[4+l]   = b[6-2*p];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic do_reset();
      RN = 1'b0; CE = 1'b0; IN_VALID = 1'b0; BITSLIP = 1'b0;
      data_a = '0; data_b = '0;
      repeat (2) @(posedge C);
      #1 RN = 1'b1;
   endtask

   task automatic test_reset();
      RN = 1'b1; CE = 1'b0; IN_VALID = 1'b0; BITSLIP = 1'b0;
      data_a = '0; data_b = '0;
      #1 RN = 1'b0;
      #2;
      checks++; if ({d1_a, d2_a} !== 2'b11) begin errors++; $display("[TB] FAIL reset_d_a: got %b want 11", {d1_a, d2_a}); end
      checks++; if ({d1_b, d2_b} !== 8'h00) begin errors++; $display("[TB] FAIL reset_d_b: got %h want 00", {d1_b, d2_b}); end
      checks++; if ({ready_a, busy_a, und_a} !== 3'b100) begin errors++; $display("[TB] FAIL reset_ctl: got %b want 100", {ready_a, busy_a, und_a}); end
      @(posedge C);
      #1 RN = 1'b1;
      CE = 1'b1;
      repeat (3) tick();
      checks++; if ({d1_a, d2_a} !== 2'b11) begin errors++; $display("[TB] FAIL post_reset_d_a: got %b want 11", {d1_a, d2_a}); end
      checks++; if ({ready_a, busy_a, und_a} !== 3'b100) begin errors++; $display("[TB] FAIL post_reset_ctl: got %b want 100", {ready_a, busy_a, und_a}); end
   endtask

   task automatic test_single_word();
      logic [1:0] exp_pair [4];
      exp_pair = '{2'b00, 2'b01, 2'b11, 2'b10};   // {D2,D1} of 8'hB4
      do_reset();
      CE = 1'b1; IN_VALID = 1'b1; data_a = 8'hB4;
      for (int t = 0; t < 4; t++) begin
         tick();
         IN_VALID = 1'b0;
         checks++; if ({d2_a, d1_a} !== exp_pair[t]) begin errors++; $display("[TB] FAIL single_pair%0d: got %b want %b", t, {d2_a, d1_a}, exp_pair[t]); end
         checks++; if (und_a !== 1'b0) begin errors++; $display("[TB] FAIL single_und_early%0d: got %b want 0", t, und_a); end
      end
      tick();
      checks++; if ({und_a, busy_a, d1_a, d2_a} !== 4'b1011) begin errors++; $display("[TB] FAIL single_end: got %b want 1011", {und_a, busy_a, d1_a, d2_a}); end
      tick();
      checks++; if ({und_a, d1_a, d2_a} !== 3'b011) begin errors++; $display("[TB] FAIL single_idle: got %b want 011", {und_a, d1_a, d2_a}); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      bit         exp_rdy [12];
      int         idx;
      logic       rdy;
      logic [1:0] p;
      words   = '{8'hFF, 8'h00, 8'hA5};
      exp_rdy = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
      do_reset();
      CE  = 1'b1;
      idx = 0;
      for (int t = 0; t < 13; t++) begin
         IN_VALID = (idx < 3);
         data_a   = (idx < 3) ? words[idx] : 8'h00;
         rdy      = ready_a;
         tick();
         if (IN_VALID && rdy) idx++;
         if (t < 12) begin
            p = ref_lsb(words[t/4], t % 4);
            checks++; if ({d2_a, d1_a} !== p) begin errors++; $display("[TB] FAIL b2b_pair%0d: got %b want %b", t, {d2_a, d1_a}, p); end
            checks++; if (und_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_und%0d: got %b want 0", t, und_a); end
            checks++; if (ready_a !== exp_rdy[t]) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %b want %b", t, ready_a, exp_rdy[t]); end
         end else begin
            checks++; if ({und_a, busy_a} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_end: got %b want 10", {und_a, busy_a}); end
         end
      end
   endtask

   task automatic test_lanes();
      logic [7:0] e;
      do_reset();
      CE = 1'b1; IN_VALID = 1'b1; data_b = 32'h8421_F00F; data_a = 8'h00;
      tick();
      IN_VALID = 1'b0;
      checks++; if ({d2_b, d1_b} !== 8'b0010_1010) begin errors++; $display("[TB] FAIL lanes_pair0_lit: got %b want 00101010", {d2_b, d1_b}); end
      for (int t = 1; t < 4; t++) begin
         tick();
         e = ref_msb4(32'h8421_F00F, t);
         checks++; if ({d2_b, d1_b} !== e) begin errors++; $display("[TB] FAIL lanes_pair%0d: got %b want %b", t, {d2_b, d1_b}, e); end
      end
      tick();
      checks++; if ({und_b, d1_b, d2_b} !== 9'b1_0000_0000) begin errors++; $display("[TB] FAIL lanes_end: got %b want 100000000", {und_b, d1_b, d2_b}); end
   endtask

   task automatic test_bitslip();
      logic [1:0] exp_pair [5];
      exp_pair = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
      do_reset();
      CE = 1'b1; IN_VALID = 1'b1; data_a = 8'hB4;
      for (int t = 0; t < 5; t++) begin
         BITSLIP = (t == 2);
         tick();
         IN_VALID = 1'b0;
         checks++; if ({d2_a, d1_a} !== exp_pair[t]) begin errors++; $display("[TB] FAIL slip_pair%0d: got %b want %b", t, {d2_a, d1_a}, exp_pair[t]); end
         checks++; if (und_a !== 1'b0) begin errors++; $display("[TB] FAIL slip_und%0d: got %b want 0", t, und_a); end
      end
      BITSLIP = 1'b0;
      tick();
      checks++; if ({und_a, d1_a, d2_a} !== 3'b111) begin errors++; $display("[TB] FAIL slip_end: got %b want 111", {und_a, d1_a, d2_a}); end
   endtask

   task automatic test_ce_reset();
      do_reset();
      CE = 1'b1; IN_VALID = 1'b1; data_a = 8'hB4; data_b = 32'hFFFF_FFFF;
      tick();
      IN_VALID = 1'b0;
      tick();
      checks++; if ({d2_a, d1_a} !== 2'b01) begin errors++; $display("[TB] FAIL ce_pair1: got %b want 01", {d2_a, d1_a}); end
      CE = 1'b0; IN_VALID = 1'b1; data_a = 8'h3C;
      tick();
      IN_VALID = 1'b0;
      checks++; if ({d2_a, d1_a, busy_a, ready_a} !== 4'b0110) begin errors++; $display("[TB] FAIL ce_freeze: got %b want 0110", {d2_a, d1_a, busy_a, ready_a}); end
      tick();
      checks++; if ({d2_a, d1_a, d1_b, d2_b} !== 10'b01_1111_1111) begin errors++; $display("[TB] FAIL ce_hold: got %b want 0111111111", {d2_a, d1_a, d1_b, d2_b}); end
      #3 RN = 1'b0;
      #1;
      checks++; if ({d2_a, d1_a, d1_b, d2_b} !== 10'b11_0000_0000) begin errors++; $display("[TB] FAIL async_reset_d: got %b want 1100000000", {d2_a, d1_a, d1_b, d2_b}); end
      checks++; if ({ready_a, busy_a} !== 2'b10) begin errors++; $display("[TB] FAIL async_reset_ctl: got %b want 10", {ready_a, busy_a}); end
      @(posedge C);
      #1 RN = 1'b1;
      CE = 1'b1;
      repeat (2) tick();
      checks++; if ({busy_a, d1_a, d2_a} !== 3'b011) begin errors++; $display("[TB] FAIL reset_discard: got %b want 011", {busy_a, d1_a, d2_a}); end
   endtask

   task automatic test_random();
      logic [7:0]  qa [$];
      logic [31:0] qb [$];
      logic [7:0]  cur_a;
      logic [31:0] cur_b;
      bit          active;
      int          emitted;
      logic        ex_und;
      logic [1:0]  ex_a;
      logic [7:0]  ex_b;
      bit          ce, vl, sl;
      do_reset();
      active = 0; emitted = 0; cur_a = '0; cur_b = '0;
      ex_a = 2'b11; ex_b = 8'h00;
      for (int cyc = 0; cyc < 600; cyc++) begin
         ce = ($urandom_range(0, 3) != 0);
         vl = ($urandom_range(0, 1) != 0);
         sl = ($urandom_range(0, 9) == 0);
         CE = ce; IN_VALID = vl; BITSLIP = sl;
         data_a = 8'($urandom); data_b = $urandom;
         // one word may wait behind the one being serialized
         if (vl && qa.size() == 0) begin
            qa.push_back(data_a);
            qb.push_back(data_b);
         end
         ex_und = 1'b0;
         if (ce) begin
            if (active && sl) begin
               ex_a = ex_a;
            end else if (active && emitted < 4) begin
               ex_a = ref_lsb(cur_a, emitted);
               ex_b = ref_msb4(cur_b, emitted);
               emitted++;
            end else if (qa.size() > 0) begin
               cur_a   = qa.pop_front();
               cur_b   = qb.pop_front();
               ex_a    = ref_lsb(cur_a, 0);
               ex_b    = ref_msb4(cur_b, 0);
               emitted = 1;
               active  = 1;
            end else begin
               ex_und = active;
               active = 0;
               ex_a   = 2'b11;
               ex_b   = 8'h00;
            end
         end
         tick();
         checks++; if ({d2_a, d1_a} !== ex_a) begin errors++; $display("[TB] FAIL rand_d_a@%0d: got %b want %b", cyc, {d2_a, d1_a}, ex_a); end
         checks++; if ({d2_b, d1_b} !== ex_b) begin errors++; $display("[TB] FAIL rand_d_b@%0d: got %b want %b", cyc, {d2_b, d1_b}, ex_b); end
         checks++; if ({und_a, und_b} !== {ex_und, ex_und}) begin errors++; $display("[TB] FAIL rand_und@%0d: got %b want %b", cyc, {und_a, und_b}, {ex_und, ex_und}); end
         checks++; if ({busy_a, busy_b} !== {active, active}) begin errors++; $display("[TB] FAIL rand_busy@%0d: got %b want %b", cyc, {busy_a, busy_b}, {active, active}); end
         checks++; if ({ready_a, ready_b} !== {2{qa.size() == 0}}) begin errors++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, {ready_a, ready_b}, {2{qa.size() == 0}}); end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_lanes();
      test_bitslip();
      test_ce_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
